// File: rtl/fib_seq_ctrl.sv
// Fibonacci fill sequencer driving a register file write port and two read ports.
// Define FIB_SAT_EN to saturate overflowing terms to all-ones instead of wrapping.
module fib_seq_ctrl #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int BASE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed0,
    input  logic [DW-1:0] seed1,
    input  logic [AW-1:0] count,
    input  logic [DW-1:0] rd0,
    input  logic [DW-1:0] rd1,
    output logic [AW-1:0] ra0,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          we,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          ovf
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        CALC,
        DONE
    } state_t;

    localparam logic [AW-1:0] MAXN = AW'(2**AW - 2 - BASE);
    localparam logic [AW-1:0] A0   = AW'(BASE);
    localparam logic [AW-1:0] A1   = AW'(BASE + 1);
    localparam logic [AW-1:0] A2   = AW'(BASE + 2);

    state_t        state, state_nx;
    logic [DW-1:0] s0, s1;
    logic [AW-1:0] n, ptr, left;
    logic [DW:0]   sum;
    logic          carry;
    logic [DW-1:0] term;

    // Next term from the two previous registers, with carry-out
    always_comb begin
        sum   = {1'b0, rd0} + {1'b0, rd1};
        carry = sum[DW];
`ifdef FIB_SAT_EN
        term  = carry ? {DW{1'b1}} : sum[DW-1:0];
`else
        term  = sum[DW-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and register file port decode
    always_comb begin
        state_nx = state;
        we       = 1'b0;
        wa       = '0;
        wd       = '0;
        ra0      = '0;
        ra1      = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = LOAD0;
            end
            LOAD0: begin
                we       = 1'b1;
                wa       = A0;
                wd       = s0;
                busy     = 1'b1;
                state_nx = LOAD1;
            end
            LOAD1: begin
                we       = 1'b1;
                wa       = A1;
                wd       = s1;
                busy     = 1'b1;
                state_nx = (n == '0) ? DONE : CALC;
            end
            CALC: begin
                ra0  = ptr - AW'(2);
                ra1  = ptr - AW'(1);
                wa   = ptr;
                wd   = term;
                we   = 1'b1;
                busy = 1'b1;
                if (left == AW'(1)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Seeds, clamped term count, pointer, result and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0     <= '0;
            s1     <= '0;
            n      <= '0;
            ptr    <= '0;
            left   <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s0  <= seed0;
                        s1  <= seed1;
                        n   <= (count > MAXN) ? MAXN : count;
                        ovf <= 1'b0;
                    end
                end
                LOAD1: begin
                    if (n == '0) begin
                        result <= s1;
                    end else begin
                        ptr  <= A2;
                        left <= n;
                    end
                end
                CALC: begin
                    ovf  <= ovf | carry;
                    ptr  <= ptr + AW'(1);
                    left <= left - AW'(1);
                    if (left == AW'(1)) result <= term;
                end
                default: ;
            endcase
        end
    end

endmodule
